// File: rtl/sdram_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_wb_bridge
//  Purpose  : Wishbone classic slave to single-word SDRAM controller bridge.
//             Hits inside the BASE_HI window become one controller request
//             each and receive one single-cycle ack. Reads wait for
//             ctrl_out_valid or give up after RD_TIMEOUT cycles.
//  Options  : define SDRAM_WB_RMW_EN to turn partial-byte writes into
//             read-modify-write sequences. Without it, sel is only used to
//             drop writes with sel=0; every other write is a full word.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_wb_bridge #(
  parameter logic [7:0] BASE_HI    = 8'h38,
  parameter logic [9:0] RD_TIMEOUT = 10'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [22:0] ctrl_addr,
  output logic        ctrl_rw,
  output logic [31:0] ctrl_wdata,
  output logic        ctrl_in_valid,
  input  logic        ctrl_busy,
  input  logic [31:0] ctrl_rdata,
  input  logic        ctrl_out_valid
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    GUARD    = 3'd2,
    RD_WAIT  = 3'd3,
    RMW_WAIT = 3'd4,
    MERGE    = 3'd5,
    ACK      = 3'd6
  } state_t;

  localparam logic [31:0] C_TIMEOUT_DATA = 32'hDEAD_BEEF;

  state_t      state_q, state_d;
  logic [22:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic        rmw_q, rmw_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        in_valid_q, in_valid_d;
  logic        rw_q, rw_d;
  logic [9:0]  tmo_q, tmo_d;

  logic        w_hit;
  logic        w_partial;
  logic [9:0]  w_tmo_next;
  logic        unused_adr_bits;

  assign w_hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
  assign w_tmo_next = tmo_q + 10'd1;

  // Byte-lane offset and the bit above the 8 MB window carry no meaning here
  assign unused_adr_bits = ^{wbs_adr_i[23], wbs_adr_i[1:0]};

`ifdef SDRAM_WB_RMW_EN
  // Only a genuinely partial write (some but not all lanes) needs the old word
  assign w_partial = (wbs_sel_i != 4'hF) && (wbs_sel_i != 4'h0);
`else
  assign w_partial = 1'b0;
`endif

  // Next-state and next-output computation for the transaction sequencer
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    rd_word_d  = rd_word_q;
    rmw_d      = rmw_q;
    rdata_d    = rdata_q;
    rw_d       = rw_q;
    tmo_d      = tmo_q;
    ack_d      = 1'b0;
    in_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_hit && !ctrl_busy) begin
          addr_d  = {wbs_adr_i[22:2], 2'b00};
          wdata_d = wbs_dat_i;
          sel_d   = wbs_sel_i;
          if (wbs_we_i && (wbs_sel_i == 4'h0)) begin
            // Nothing to write: acknowledge without touching the controller
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            rw_d       = wbs_we_i & ~w_partial;
            rmw_d      = wbs_we_i & w_partial;
            in_valid_d = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: state_d = GUARD;
      GUARD: begin
        // Controller busy is not yet valid here; it lags acceptance by a cycle
        tmo_d = 10'd0;
        if (rw_q) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else if (rmw_q) begin
          state_d = RMW_WAIT;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT, RMW_WAIT: begin
        if (ctrl_out_valid) begin
          if (state_q == RMW_WAIT) begin
            rd_word_d = ctrl_rdata;
            state_d   = MERGE;
          end else begin
            rdata_d = ctrl_rdata;
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end else begin
          tmo_d = w_tmo_next;
          if (w_tmo_next == RD_TIMEOUT) begin
            rdata_d = C_TIMEOUT_DATA;
            rmw_d   = 1'b0;
            state_d = ACK;
            ack_d   = 1'b1;
          end
        end
      end
      MERGE: begin
        // Idempotent: enabled lanes keep bus data, others take the old word
        for (int b = 0; b < 4; b++) begin
          wdata_d[8*b +: 8] = sel_q[b] ? wdata_q[8*b +: 8] : rd_word_q[8*b +: 8];
        end
        if (!ctrl_busy) begin
          rw_d       = 1'b1;
          rmw_d      = 1'b0;
          in_valid_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      rd_word_q  <= '0;
      rmw_q      <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      in_valid_q <= 1'b0;
      rw_q       <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      rd_word_q  <= rd_word_d;
      rmw_q      <= rmw_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      in_valid_q <= in_valid_d;
      rw_q       <= rw_d;
      tmo_q      <= tmo_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = rdata_q;
  assign ctrl_addr     = addr_q;
  assign ctrl_rw       = rw_q;
  assign ctrl_wdata    = wdata_q;
  assign ctrl_in_valid = in_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_wb_bridge
//  Purpose  : Directed self-checking bench for sdram_wb_bridge with a small
//             single-word controller responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [22:0] ctrl_addr;
  logic        ctrl_rw;
  logic [31:0] ctrl_wdata;
  logic        ctrl_in_valid;
  logic        ctrl_busy;
  logic [31:0] ctrl_rdata = 32'h0;
  logic        ctrl_out_valid = 1'b0;

  sdram_wb_bridge dut (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy),
    .ctrl_rdata(ctrl_rdata), .ctrl_out_valid(ctrl_out_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc_n = 0;
  int          n_req = 0;
  int          n_ack = 0;
  int          rd_cnt = 0;
  int          resp_delay = 4;
  bit          resp_en = 1'b1;
  int          valid_cyc = 0;
  int          ack_cyc = 0;
  int          req_cyc = 0;
  logic [22:0] last_addr = '0;
  logic        last_rw = 1'b0;
  logic [31:0] last_wdata = '0;
  logic [31:0] mem_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Controller model and bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc_n++;
    ctrl_out_valid = 1'b0;
    if (rst) begin
      rd_cnt = 0;
    end else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        ctrl_out_valid = 1'b1;
        ctrl_rdata     = mem_word;
        valid_cyc      = cyc_n;
      end
    end
    if (ctrl_in_valid) begin
      n_req++;
      req_cyc    = cyc_n;
      last_addr  = ctrl_addr;
      last_rw    = ctrl_rw;
      last_wdata = ctrl_wdata;
      if (ctrl_rw) mem_word = ctrl_wdata;
      else if (resp_en) rd_cnt = resp_delay;
    end
    if (wbs_ack_o) begin
      n_ack++;
      ack_cyc = cyc_n;
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int max_cyc, output logic got);
    got = 1'b0;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (wbs_ack_o) got = 1'b1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   r0, a0;
    logic got;
    rst = 1'b1; ctrl_busy = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("rst_dat", wbs_dat_o, 32'h0);
    chk("rst_inv", {31'b0, ctrl_in_valid}, 32'h0);
    chk("rst_rw", {31'b0, ctrl_rw}, 32'h0);
    chk("rst_addr", {9'b0, ctrl_addr}, 32'h0);
    chk("rst_wdata", ctrl_wdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full-word posted write
    r0 = n_req; a0 = n_ack;
    wb_xfer(1'b1, 32'h3800_0010, 32'h1234_5678, 4'hF, 20, got);
    chk("wr_got", {31'b0, got}, 32'h1);
    chk("wr_nreq", n_req - r0, 1);
    chk("wr_rw", {31'b0, last_rw}, 32'h1);
    chk("wr_addr", {9'b0, last_addr}, 32'h10);
    chk("wr_wdata", last_wdata, 32'h1234_5678);
    chk("wr_nack", n_ack - a0, 1);

    // Read with data returned 4 cycles after the request
    r0 = n_req; a0 = n_ack; resp_delay = 4;
    wb_xfer(1'b0, 32'h3800_0013, 32'h0, 4'hF, 30, got);
    chk("rd_got", {31'b0, got}, 32'h1);
    chk("rd_dat", wbs_dat_o, 32'h1234_5678);
    chk("rd_nreq", n_req - r0, 1);
    chk("rd_rw", {31'b0, last_rw}, 32'h0);
    chk("rd_addr", {9'b0, last_addr}, 32'h10);
    chk("rd_ack_lat", ack_cyc - valid_cyc, 1);
    chk("rd_nack", n_ack - a0, 1);

    // Partial write; the stored word is 0xAABBCCDD beforehand
    mem_word = 32'hAABB_CCDD;
    r0 = n_req; a0 = n_ack;
    wb_xfer(1'b1, 32'h3800_0010, 32'h1122_3344, 4'b0101, 40, got);
    chk("pw_got", {31'b0, got}, 32'h1);
    chk("pw_nack", n_ack - a0, 1);
    chk("pw_rw", {31'b0, last_rw}, 32'h1);
`ifdef SDRAM_WB_RMW_EN
    chk("pw_nreq", n_req - r0, 2);
    chk("pw_wdata", last_wdata, 32'hAA22_CC44);
`else
    chk("pw_nreq", n_req - r0, 1);
    chk("pw_wdata", last_wdata, 32'h1122_3344);
`endif

    // sel=0 write: ack with no controller request
    r0 = n_req; a0 = n_ack;
    wb_xfer(1'b1, 32'h3800_0040, 32'hFFFF_FFFF, 4'h0, 20, got);
    chk("sel0_got", {31'b0, got}, 32'h1);
    chk("sel0_nreq", n_req - r0, 0);
    chk("sel0_nack", n_ack - a0, 1);

    // Hit held off by a busy controller for 10 cycles
    r0 = n_req; a0 = n_ack; ctrl_busy = 1'b1;
    fork
      wb_xfer(1'b1, 32'h3800_0020, 32'h5555_AAAA, 4'hF, 40, got);
      begin
        repeat (10) @(negedge clk);
        chk("busy_hold", n_req - r0, 0);
        ctrl_busy = 1'b0;
      end
    join
    chk("busy_got", {31'b0, got}, 32'h1);
    chk("busy_nreq", n_req - r0, 1);
    chk("busy_addr", {9'b0, last_addr}, 32'h20);

    // Outside the window: never acked, never forwarded
    r0 = n_req; a0 = n_ack;
    wb_xfer(1'b1, 32'h3000_0000, 32'h1, 4'hF, 20, got);
    chk("miss_got", {31'b0, got}, 32'h0);
    chk("miss_nreq", n_req - r0, 0);
    chk("miss_nack", n_ack - a0, 0);

    // Cycle dropped mid-read still completes and acks
    mem_word = 32'hCAFE_0001; a0 = n_ack;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0030;
    repeat (2) @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (15) @(negedge clk);
    chk("drop_nack", n_ack - a0, 1);
    chk("drop_dat", wbs_dat_o, 32'hCAFE_0001);

    // Read timeout: request, ISSUE, GUARD, 1023 wait cycles, then ack
    resp_en = 1'b0; a0 = n_ack;
    wb_xfer(1'b0, 32'h3800_0050, 32'h0, 4'hF, 1100, got);
    chk("tmo_got", {31'b0, got}, 32'h1);
    chk("tmo_dat", wbs_dat_o, 32'hDEAD_BEEF);
    chk("tmo_lat", ack_cyc - req_cyc, 1025);
    chk("tmo_nack", n_ack - a0, 1);

    // Reset while waiting for read data
    r0 = n_req; a0 = n_ack;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3800_0064;
    repeat (6) @(negedge clk);
    chk("rstw_issued", n_req - r0, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_ack", {31'b0, wbs_ack_o}, 32'h0);
    chk("rstw_dat", wbs_dat_o, 32'h0);
    chk("rstw_addr", {9'b0, ctrl_addr}, 32'h0);
    chk("rstw_wdata", ctrl_wdata, 32'h0);
    chk("rstw_inv", {31'b0, ctrl_in_valid}, 32'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstw_noack", n_ack - a0, 0);
    chk("rstw_noreq", n_req - r0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
